// File: rtl/fetch_ctrl.sv
// Instruction fetch front end: issues word fetches, splits each word into
// 16-bit instructions and queues them with their PCs for decode.
module fetch_ctrl #(
  parameter int            RV       = 32,
  parameter logic [RV-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic          ifetch_req,
  output logic [RV-1:0] ifetch_addr,
  input  logic          ifetch_ack,
  input  logic [31:0]   ifetch_data,
  output logic [15:0]   ins,
  output logic [RV-1:0] ins_pc,
  output logic          idone,
  input  logic          stall,
  input  logic          redirect,
  input  logic [RV-1:0] redirect_pc,
  output logic [2:0]    qcount
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state_reg, state_next;
  logic [RV-1:0] fpc_reg, fpc_next;
  logic [RV-1:0] addr_reg;
  logic [1:0]    head_reg, tail_reg;
  logic [2:0]    count_reg;
  logic [15:0]   ins_mem [4];
  logic [RV-1:0] pc_mem  [4];

  logic [RV-1:0] fpc_word;
  logic [1:0]    tail_plus1;
  logic          take_ack, push_two, push_one, launch;

  assign fpc_word   = {fpc_reg[RV-1:2], 2'b00};
  assign tail_plus1 = tail_reg + 2'd1;

  // Data is only accepted from a live request; acks in DROP or under redirect are discarded.
  assign take_ack = !reset && (state_reg == WAIT) && ifetch_ack && !redirect;
  assign push_two = take_ack && !fpc_reg[1];
  assign push_one = take_ack && fpc_reg[1];
  // Requesting only at count<=2 leaves room for the two halfwords of the reply.
  assign launch   = (state_reg == IDLE) && !redirect && (count_reg <= 3'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (launch) state_next = WAIT;
      WAIT:    if (ifetch_ack) state_next = IDLE;
               else if (redirect) state_next = DROP;
      DROP:    if (ifetch_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ifetch_req = !reset && (state_reg != IDLE);
    idone      = !reset && (count_reg != 3'd0) && !stall && !redirect;
  end

  always_comb begin
    fpc_next = fpc_reg;
    if (redirect) begin
      fpc_next = redirect_pc;
    end else if (take_ack) begin
      fpc_next = fpc_word + {{(RV-3){1'b0}}, 3'd4};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_reg   <= RESET_PC;
      addr_reg  <= '0;
      head_reg  <= 2'd0;
      tail_reg  <= 2'd0;
      count_reg <= 3'd0;
    end else begin
      fpc_reg <= fpc_next;
      if (launch) addr_reg <= fpc_word;
      if (redirect) begin
        head_reg  <= 2'd0;
        tail_reg  <= 2'd0;
        count_reg <= 3'd0;
      end else begin
        if (push_two) tail_reg <= tail_reg + 2'd2;
        else if (push_one) tail_reg <= tail_plus1;
        if (idone) head_reg <= head_reg + 2'd1;
        count_reg <= count_reg + {1'b0, push_two, push_one} - {2'b00, idone};
      end
    end
  end

  // A halfword-aligned fpc enters the word at its upper half, so only that half is queued.
  always_ff @(posedge clk) begin
    if (push_two) begin
      ins_mem[tail_reg]   <= ifetch_data[15:0];
      pc_mem[tail_reg]    <= fpc_reg;
      ins_mem[tail_plus1] <= ifetch_data[31:16];
      pc_mem[tail_plus1]  <= fpc_reg + {{(RV-2){1'b0}}, 2'd2};
    end else if (push_one) begin
      ins_mem[tail_reg] <= ifetch_data[31:16];
      pc_mem[tail_reg]  <= fpc_reg;
    end
  end

  assign ifetch_addr = addr_reg;
  assign ins         = ins_mem[head_reg];
  assign ins_pc      = pc_mem[head_reg];
  assign qcount      = count_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: acts as instruction memory, queues expected
// {ins, pc} pairs and checks them against every idone from a separate monitor.
module tb_fetch_ctrl;

  localparam int RV = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          ifetch_req;
  logic [RV-1:0] ifetch_addr;
  logic          ifetch_ack;
  logic [31:0]   ifetch_data;
  logic [15:0]   ins;
  logic [RV-1:0] ins_pc;
  logic          idone;
  logic          stall;
  logic          redirect;
  logic [RV-1:0] redirect_pc;
  logic [2:0]    qcount;

  typedef struct packed {
    logic [15:0] ins;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  fetch_ctrl #(.RV(RV), .RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset),
    .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr),
    .ifetch_ack(ifetch_ack), .ifetch_data(ifetch_data),
    .ins(ins), .ins_pc(ins_pc), .idone(idone),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .qcount(qcount)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (idone) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_idone: got ins=%h pc=%h, expected no instruction", ins, ins_pc);
      end else begin
        mon_e = sb.pop_front();
        if (ins !== mon_e.ins || ins_pc !== mon_e.pc) begin
          fails++;
          $display("FAIL decode_order: got ins=%h pc=%h, expected ins=%h pc=%h",
                   ins, ins_pc, mon_e.ins, mon_e.pc);
        end else begin
          $display("[TB] decode ins=%h pc=%h", ins, ins_pc);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ins(input logic [15:0] i, input logic [31:0] pc);
    sb.push_back({i, pc});
  endtask

  task automatic wait_req(input logic [31:0] addr);
    int n = 0;
    while (!ifetch_req && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", {31'd0, ifetch_req}, 32'd1);
    check("ifetch_addr", ifetch_addr, addr);
  endtask

  task automatic wait_empty;
    int n = 0;
    while (qcount != 3'd0 && n < 20) begin
      tick();
      n++;
    end
    check("queue_drained", {29'd0, qcount}, 32'd0);
  endtask

  task automatic ack_now(input logic [31:0] data);
    ifetch_ack  = 1'b1;
    ifetch_data = data;
    tick();
    ifetch_ack  = 1'b0;
    ifetch_data = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ifetch_ack = 1'b0; ifetch_data = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    check("reset_req", {31'd0, ifetch_req}, 32'd0);
    check("reset_qcount", {29'd0, qcount}, 32'd0);
    check("reset_idone", {31'd0, idone}, 32'd0);

    // Basic aligned fetch from RESET_PC, ack after two waiting cycles
    reset = 1'b0;
    check("first_cycle_req", {31'd0, ifetch_req}, 32'd0);
    tick();
    check("second_cycle_req", {31'd0, ifetch_req}, 32'd1);
    check("reset_pc_addr", ifetch_addr, 32'h100);
    tick(); tick();
    expect_ins(16'hAAAA, 32'h100);
    expect_ins(16'hBBBB, 32'h102);
    ack_now(32'hBBBBAAAA);
    check("ack_latency_idone", {31'd0, idone}, 32'd1);
    check("ack_qcount", {29'd0, qcount}, 32'd2);

    // Redirect while waiting: stale reply must be dropped
    wait_req(32'h104);
    wait_empty();
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("drop_req_held", {31'd0, ifetch_req}, 32'd1);
      check("drop_addr_stable", ifetch_addr, 32'h104);
      check("drop_qcount", {29'd0, qcount}, 32'd0);
      if (i < 2) tick();
    end
    ack_now(32'hDEADBEEF);
    check("stale_not_pushed", {29'd0, qcount}, 32'd0);
    check("drop_to_idle", {31'd0, ifetch_req}, 32'd0);
    wait_req(32'h300);
    expect_ins(16'h3333, 32'h300);
    expect_ins(16'h4444, 32'h302);
    ack_now(32'h44443333);

    // Redirect in the same cycle as an ack: queue flushed, idone suppressed
    wait_req(32'h304);
    check("pre_flush_qcount", {29'd0, qcount}, 32'd1);
    void'(sb.pop_back());
    ifetch_ack = 1'b1; ifetch_data = 32'h55555555;
    redirect = 1'b1; redirect_pc = 32'h400;
    #1;
    check("redirect_blocks_idone", {31'd0, idone}, 32'd0);
    tick();
    ifetch_ack = 1'b0; ifetch_data = '0;
    check("flush_qcount", {29'd0, qcount}, 32'd0);
    check("flush_idle", {31'd0, ifetch_req}, 32'd0);

    // Redirect in IDLE to a halfword-aligned PC
    redirect_pc = 32'h206;
    tick();
    redirect = 1'b0;
    check("idle_redirect_stays_idle", {31'd0, ifetch_req}, 32'd0);
    tick();
    wait_req(32'h204);
    expect_ins(16'h2222, 32'h206);
    ack_now(32'h22221111);
    check("upper_only_qcount", {29'd0, qcount}, 32'd1);

    // Stall fills the queue to 4; no request while count>2
    wait_req(32'h208);
    check("pre_stall_qcount", {29'd0, qcount}, 32'd0);
    stall = 1'b1;
    expect_ins(16'h5555, 32'h208);
    expect_ins(16'h6666, 32'h20A);
    ack_now(32'h66665555);
    wait_req(32'h20C);
    expect_ins(16'h7777, 32'h20C);
    expect_ins(16'h8888, 32'h20E);
    ack_now(32'h88887777);
    for (int i = 0; i < 4; i++) begin
      check("full_qcount", {29'd0, qcount}, 32'd4);
      check("full_no_req", {31'd0, ifetch_req}, 32'd0);
      tick();
    end
    stall = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("drain_idone", {31'd0, idone}, 32'd1);
      tick();
    end

    // Pop and push in the same cycle with count=2
    wait_req(32'h210);
    check("pre_pp_qcount", {29'd0, qcount}, 32'd0);
    stall = 1'b1;
    expect_ins(16'h9999, 32'h210);
    expect_ins(16'hAAAA, 32'h212);
    ack_now(32'hAAAA9999);
    check("pp_setup_qcount", {29'd0, qcount}, 32'd2);
    wait_req(32'h214);
    expect_ins(16'hBBBB, 32'h214);
    expect_ins(16'hCCCC, 32'h216);
    stall = 1'b0;
    ifetch_ack = 1'b1; ifetch_data = 32'hCCCCBBBB;
    #1;
    check("pp_idone", {31'd0, idone}, 32'd1);
    check("pp_count_before", {29'd0, qcount}, 32'd2);
    tick();
    ifetch_ack = 1'b0; ifetch_data = '0;
    stall = 1'b1;
    check("pp_count_after", {29'd0, qcount}, 32'd3);
    tick();
    check("pp_hold_qcount", {29'd0, qcount}, 32'd3);
    check("pp_no_req", {31'd0, ifetch_req}, 32'd0);
    stall = 1'b0;
    wait_empty();

    // Reset while a request is outstanding
    wait_req(32'h218);
    reset = 1'b1;
    tick();
    check("rst_wait_req", {31'd0, ifetch_req}, 32'd0);
    check("rst_wait_qcount", {29'd0, qcount}, 32'd0);
    ifetch_ack = 1'b1; ifetch_data = 32'hFFFFFFFF;
    tick();
    ifetch_ack = 1'b0; ifetch_data = '0;
    reset = 1'b0;
    check("rst_ack_ignored", {29'd0, qcount}, 32'd0);
    check("rst_release_req", {31'd0, ifetch_req}, 32'd0);
    tick();
    check("refetch_req", {31'd0, ifetch_req}, 32'd1);
    check("refetch_addr", ifetch_addr, 32'h100);
    expect_ins(16'h5678, 32'h100);
    expect_ins(16'h1234, 32'h102);
    ack_now(32'h12345678);
    wait_empty();
    tick(); tick();
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
